// File: rtl/arbitro_escritura_reg.sv
// -----------------------------------------------------------------------------
// arbitro_escritura_reg
//
// Register-file write-back arbiter with a pending-write scoreboard.
// Two producers (ALU and load unit) compete for the single register-file
// write port. The grant is combinational. The winning address/data pair is
// registered and presented on the write port one cycle later. A 32-bit
// scoreboard marks destinations that the issue stage has reserved. A mark is
// cleared on the edge where the register file performs the write.
//
// Parameters
//   RR_EN         1 = round-robin on conflict, 0 = ALU always wins
//
// Ports
//   clk           clock, all state on posedge
//   rst           synchronous active-high reset
//   alu_valid/addr/data, alu_ready   ALU write-back request / accept
//   mem_valid/addr/data, mem_ready   load-unit write-back request / accept
//   reserve_en/addr                  mark a destination register pending
//   rs1_addr, rs2_addr               decode-stage source registers
//   hazard                           a source register is pending (stall)
//   write_enable/addr/data           register-file write port
//   busy                             scoreboard, one bit per register
// -----------------------------------------------------------------------------
module arbitro_escritura_reg #(
    parameter bit RR_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [4:0]  alu_addr,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    input  logic        mem_valid,
    input  logic [4:0]  mem_addr,
    input  logic [31:0] mem_data,
    output logic        mem_ready,
    input  logic        reserve_en,
    input  logic [4:0]  reserve_addr,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    output logic        hazard,
    output logic        write_enable,
    output logic [4:0]  write_addr,
    output logic [31:0] write_data,
    output logic [31:0] busy
);

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } src_e;

    src_e        last_grant_q, last_grant_d;
    logic        write_enable_q, write_enable_d;
    logic [4:0]  write_addr_q, write_addr_d;
    logic [31:0] write_data_q, write_data_d;
    logic [31:0] busy_q, busy_d;

    logic        xfer_alu, xfer_mem, xfer;
    logic [4:0]  xfer_addr;
    logic [31:0] xfer_data;

    // Grant depends only on the current inputs and the last winner, so a
    // rejected requester is free to drop or change its request.
    always_comb begin
        alu_ready = 1'b0;
        mem_ready = 1'b0;
        if (alu_valid && mem_valid) begin
            if (RR_EN && (last_grant_q == SRC_ALU)) begin
                mem_ready = 1'b1;
            end else begin
                alu_ready = 1'b1;
            end
        end else begin
            alu_ready = alu_valid;
            mem_ready = mem_valid;
        end
    end

    assign xfer_alu  = alu_valid && alu_ready;
    assign xfer_mem  = mem_valid && mem_ready;
    assign xfer      = xfer_alu || xfer_mem;
    assign xfer_addr = xfer_mem ? mem_addr : alu_addr;
    assign xfer_data = xfer_mem ? mem_data : alu_data;

    always_comb begin
        last_grant_d   = last_grant_q;
        write_enable_d = 1'b0;
        write_addr_d   = write_addr_q;
        write_data_d   = write_data_q;
        busy_d         = busy_q;

        if (xfer) begin
            last_grant_d   = xfer_mem ? SRC_MEM : SRC_ALU;
            // x0 is hard-wired zero: accept the request but never write it.
            write_enable_d = (xfer_addr != 5'd0);
            write_addr_d   = xfer_addr;
            write_data_d   = xfer_data;
        end

        // Clear on the edge the register file actually writes; a new
        // reservation on the same edge is applied after and therefore wins.
        if (write_enable_q) begin
            busy_d[write_addr_q] = 1'b0;
        end
        if (reserve_en && (reserve_addr != 5'd0)) begin
            busy_d[reserve_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // MEM as last winner makes the ALU win the first conflict.
            last_grant_q   <= SRC_MEM;
            write_enable_q <= 1'b0;
            write_addr_q   <= 5'd0;
            write_data_q   <= 32'd0;
            busy_q         <= 32'd0;
        end else begin
            last_grant_q   <= last_grant_d;
            write_enable_q <= write_enable_d;
            write_addr_q   <= write_addr_d;
            write_data_q   <= write_data_d;
            busy_q         <= busy_d;
        end
    end

    assign write_enable = write_enable_q;
    assign write_addr   = write_addr_q;
    assign write_data   = write_data_q;
    assign busy         = busy_q;

    // Still high during the write_enable cycle: the asynchronous-read
    // register file only shows the new value after that edge.
    assign hazard = ((rs1_addr != 5'd0) && busy_q[rs1_addr]) ||
                    ((rs2_addr != 5'd0) && busy_q[rs2_addr]);

endmodule

// File: tb/tb_arbitro_escritura_reg.sv
module tb_arbitro_escritura_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, mem_valid, reserve_en;
    logic [4:0]  alu_addr, mem_addr, reserve_addr, rs1_addr, rs2_addr;
    logic [31:0] alu_data, mem_data;

    logic        alu_ready, mem_ready, hazard, write_enable;
    logic [4:0]  write_addr;
    logic [31:0] write_data, busy;

    logic        fp_alu_ready, fp_mem_ready, fp_hazard, fp_write_enable;
    logic [4:0]  fp_write_addr;
    logic [31:0] fp_write_data, fp_busy;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    arbitro_escritura_reg #(.RR_EN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
        .reserve_en(reserve_en), .reserve_addr(reserve_addr),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .hazard(hazard),
        .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
        .busy(busy)
    );

    arbitro_escritura_reg #(.RR_EN(1'b0)) dut_fp (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(fp_alu_ready),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(fp_mem_ready),
        .reserve_en(reserve_en), .reserve_addr(reserve_addr),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .hazard(fp_hazard),
        .write_enable(fp_write_enable), .write_addr(fp_write_addr), .write_data(fp_write_data),
        .busy(fp_busy)
    );

    // Reference model of the round-robin instance.
    // m_last: 0 = ALU won the last transfer, 1 = MEM won it.
    int          m_last = 1;
    bit [31:0]   m_busy = '0;
    bit          m_we   = 1'b0;
    bit [4:0]    m_wa   = '0;
    bit [31:0]   m_wd   = '0;

    function automatic bit model_alu_gnt();
        if (!alu_valid) return 1'b0;
        if (!mem_valid) return 1'b1;
        return (m_last == 1);   // the one that did not win last time
    endfunction

    function automatic bit model_mem_gnt();
        if (!mem_valid) return 1'b0;
        if (!alu_valid) return 1'b1;
        return (m_last == 0);
    endfunction

    function automatic bit model_hazard();
        return (rs1_addr != 0 && m_busy[rs1_addr] == 1'b1) ||
               (rs2_addr != 0 && m_busy[rs2_addr] == 1'b1);
    endfunction

    // Advance one clock and update the model from the inputs seen at the edge.
    task automatic tick();
        bit ga, gm;
        bit [31:0] nb;
        ga = model_alu_gnt();
        gm = model_mem_gnt();
        nb = m_busy;
        if (m_we) nb[m_wa] = 1'b0;
        if (reserve_en && reserve_addr != 0) nb[reserve_addr] = 1'b1;
        @(posedge clk);
        if (rst) begin
            m_last = 1; m_busy = '0; m_we = 1'b0; m_wa = '0; m_wd = '0;
        end else begin
            m_busy = nb;
            m_we   = 1'b0;
            if (ga) begin
                m_last = 0; m_wa = alu_addr; m_wd = alu_data; m_we = (alu_addr != 0);
            end else if (gm) begin
                m_last = 1; m_wa = mem_addr; m_wd = mem_data; m_we = (mem_addr != 0);
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        rst = 1'b0; alu_valid = 1'b0; mem_valid = 1'b0; reserve_en = 1'b0;
        alu_addr = '0; mem_addr = '0; reserve_addr = '0; rs1_addr = '0; rs2_addr = '0;
        alu_data = '0; mem_data = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        alu_valid = 1'b1; alu_addr = 5'd4; alu_data = 32'h1234; reserve_en = 1'b1; reserve_addr = 5'd9;
        rst = 1'b1;
        tick(); tick();
        idle_inputs();
        #1;
        n_cmp++; if (write_enable !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b want 0", write_enable); end
        n_cmp++; if (write_addr !== 5'd0) begin n_fail++; $display("FAIL reset_wa got %0d want 0", write_addr); end
        n_cmp++; if (write_data !== 32'd0) begin n_fail++; $display("FAIL reset_wd got %h want 0", write_data); end
        n_cmp++; if (busy !== 32'd0) begin n_fail++; $display("FAIL reset_busy got %h want 0", busy); end
        n_cmp++; if ({alu_ready, mem_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_ready got %b want 00", {alu_ready, mem_ready}); end
    endtask

    task automatic test_lone_request();
        do_reset();
        alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'hDEADBEEF;
        #1;
        n_cmp++; if ({alu_ready, mem_ready} !== 2'b10) begin n_fail++; $display("FAIL lone_alu_ready got %b want 10", {alu_ready, mem_ready}); end
        n_cmp++; if (write_enable !== 1'b0) begin n_fail++; $display("FAIL lone_we_early got %b want 0", write_enable); end
        tick();
        alu_valid = 1'b0;
        #1;
        n_cmp++; if (write_enable !== 1'b1) begin n_fail++; $display("FAIL lone_we got %b want 1", write_enable); end
        n_cmp++; if (write_addr !== 5'd5) begin n_fail++; $display("FAIL lone_wa got %0d want 5", write_addr); end
        n_cmp++; if (write_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lone_wd got %h want deadbeef", write_data); end
        tick();
        n_cmp++; if (write_enable !== 1'b0) begin n_fail++; $display("FAIL lone_we_drop got %b want 0", write_enable); end
        n_cmp++; if (write_addr !== 5'd5 || write_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lone_hold got %0d/%h want 5/deadbeef", write_addr, write_data); end
        // lone load-unit request
        mem_valid = 1'b1; mem_addr = 5'd17; mem_data = 32'hCAFE0001;
        #1;
        n_cmp++; if ({alu_ready, mem_ready} !== 2'b01) begin n_fail++; $display("FAIL lone_mem_ready got %b want 01", {alu_ready, mem_ready}); end
        tick();
        mem_valid = 1'b0;
        n_cmp++; if (write_enable !== 1'b1 || write_addr !== 5'd17 || write_data !== 32'hCAFE0001) begin
            n_fail++; $display("FAIL lone_mem_write got %b/%0d/%h want 1/17/cafe0001", write_enable, write_addr, write_data); end
        tick();
    endtask

    task automatic test_conflict();
        bit [4:0] exp_wa [3];
        bit [1:0] exp_rdy [3];
        exp_rdy[0] = 2'b10; exp_rdy[1] = 2'b01; exp_rdy[2] = 2'b10;
        exp_wa[0]  = 5'd10; exp_wa[1]  = 5'd11; exp_wa[2]  = 5'd10;
        do_reset();
        alu_valid = 1'b1; alu_addr = 5'd10; alu_data = 32'hA0A0;
        mem_valid = 1'b1; mem_addr = 5'd11; mem_data = 32'hB0B0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if ({alu_ready, mem_ready} !== exp_rdy[i]) begin n_fail++; $display("FAIL rr_grant[%0d] got %b want %b", i, {alu_ready, mem_ready}, exp_rdy[i]); end
            n_cmp++; if ({fp_alu_ready, fp_mem_ready} !== 2'b10) begin n_fail++; $display("FAIL fp_grant[%0d] got %b want 10", i, {fp_alu_ready, fp_mem_ready}); end
            tick();
            n_cmp++; if (write_enable !== 1'b1 || write_addr !== exp_wa[i]) begin n_fail++; $display("FAIL rr_wa[%0d] got %b/%0d want 1/%0d", i, write_enable, write_addr, exp_wa[i]); end
            n_cmp++; if (fp_write_enable !== 1'b1 || fp_write_addr !== 5'd10) begin n_fail++; $display("FAIL fp_wa[%0d] got %b/%0d want 1/10", i, fp_write_enable, fp_write_addr); end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_scoreboard();
        do_reset();
        reserve_en = 1'b1; reserve_addr = 5'd7;
        tick();
        reserve_en = 1'b0; rs1_addr = 5'd7;
        #1;
        n_cmp++; if (hazard !== 1'b1) begin n_fail++; $display("FAIL sb_hazard_set got %b want 1", hazard); end
        n_cmp++; if (busy[7] !== 1'b1) begin n_fail++; $display("FAIL sb_busy7 got %b want 1", busy[7]); end
        mem_valid = 1'b1; mem_addr = 5'd7; mem_data = 32'h77;
        tick();
        mem_valid = 1'b0;
        #1;
        n_cmp++; if (write_enable !== 1'b1 || hazard !== 1'b1) begin n_fail++; $display("FAIL sb_hazard_during_we got we=%b hz=%b want 1/1", write_enable, hazard); end
        tick();
        n_cmp++; if (hazard !== 1'b0 || busy[7] !== 1'b0) begin n_fail++; $display("FAIL sb_hazard_clear got hz=%b busy7=%b want 0/0", hazard, busy[7]); end
        // rs2 path
        reserve_en = 1'b1; reserve_addr = 5'd20; rs1_addr = 5'd0; rs2_addr = 5'd20;
        tick();
        reserve_en = 1'b0;
        n_cmp++; if (hazard !== 1'b1) begin n_fail++; $display("FAIL sb_hazard_rs2 got %b want 1", hazard); end
        rs2_addr = 5'd21;
        #1;
        n_cmp++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL sb_hazard_other got %b want 0", hazard); end
    endtask

    task automatic test_same_edge_and_x0();
        do_reset();
        reserve_en = 1'b1; reserve_addr = 5'd3;
        tick();
        reserve_en = 1'b0;
        alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'h33;
        tick();
        alu_valid = 1'b0;
        reserve_en = 1'b1; reserve_addr = 5'd3;   // same edge as the write of x3
        #1;
        n_cmp++; if (write_enable !== 1'b1 || write_addr !== 5'd3) begin n_fail++; $display("FAIL se_write got %b/%0d want 1/3", write_enable, write_addr); end
        tick();
        reserve_en = 1'b0;
        n_cmp++; if (busy[3] !== 1'b1) begin n_fail++; $display("FAIL se_set_wins got %b want 1", busy[3]); end
        reserve_en = 1'b1; reserve_addr = 5'd0; rs1_addr = 5'd0; rs2_addr = 5'd0;
        tick();
        reserve_en = 1'b0;
        n_cmp++; if (busy[0] !== 1'b0 || hazard !== 1'b0) begin n_fail++; $display("FAIL x0_reserve got busy0=%b hz=%b want 0/0", busy[0], hazard); end
        alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'h5555;
        #1;
        n_cmp++; if (alu_ready !== 1'b1) begin n_fail++; $display("FAIL x0_ready got %b want 1", alu_ready); end
        tick();
        alu_valid = 1'b0;
        n_cmp++; if (write_enable !== 1'b0) begin n_fail++; $display("FAIL x0_no_write got %b want 0", write_enable); end
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        alu_valid = 1'b1; alu_addr = 5'd9; alu_data = 32'h99; reserve_en = 1'b1; reserve_addr = 5'd12;
        tick();                       // edge N: ALU transfer, x12 reserved
        alu_valid = 1'b0; reserve_en = 1'b0;
        rst = 1'b1;
        tick();                       // edge N+1: reset
        rst = 1'b0;
        n_cmp++; if (write_enable !== 1'b0 || busy !== 32'd0) begin n_fail++; $display("FAIL mid_reset got we=%b busy=%h want 0/0", write_enable, busy); end
        alu_valid = 1'b1; alu_addr = 5'd1; mem_valid = 1'b1; mem_addr = 5'd2;
        #1;
        n_cmp++; if ({alu_ready, mem_ready} !== 2'b10) begin n_fail++; $display("FAIL mid_first_conflict got %b want 10", {alu_ready, mem_ready}); end
        idle_inputs();
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            rst          = ($urandom_range(0, 39) == 0);
            alu_valid    = ($urandom_range(0, 9) < 6);
            mem_valid    = ($urandom_range(0, 9) < 6);
            alu_addr     = 5'($urandom_range(0, 7));
            mem_addr     = 5'($urandom_range(0, 7));
            alu_data     = $urandom;
            mem_data     = $urandom;
            reserve_en   = ($urandom_range(0, 9) < 3);
            reserve_addr = 5'($urandom_range(0, 7));
            rs1_addr     = 5'($urandom_range(0, 7));
            rs2_addr     = 5'($urandom_range(0, 7));
            #1;
            n_cmp++; if ({alu_ready, mem_ready} !== {model_alu_gnt(), model_mem_gnt()}) begin
                n_fail++; $display("FAIL rnd_grant[%0d] got %b want %b", c, {alu_ready, mem_ready}, {model_alu_gnt(), model_mem_gnt()}); end
            n_cmp++; if (hazard !== model_hazard()) begin n_fail++; $display("FAIL rnd_hazard[%0d] got %b want %b", c, hazard, model_hazard()); end
            n_cmp++; if (busy !== m_busy) begin n_fail++; $display("FAIL rnd_busy[%0d] got %h want %h", c, busy, m_busy); end
            n_cmp++; if (write_enable !== m_we) begin n_fail++; $display("FAIL rnd_we[%0d] got %b want %b", c, write_enable, m_we); end
            if (m_we) begin
                n_cmp++; if (write_addr !== m_wa || write_data !== m_wd) begin
                    n_fail++; $display("FAIL rnd_wdata[%0d] got %0d/%h want %0d/%h", c, write_addr, write_data, m_wa, m_wd); end
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_lone_request();
        test_conflict();
        test_scoreboard();
        test_same_edge_and_x0();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/arbitro_escritura_reg.md
ARBITRO_ESCRITURA_REG -- requirements
Module: arbitro_escritura_reg

Interface
REQ-001 SHALL have parameter RR_EN, default 1: 1 = round-robin arbitration; 0 = fixed priority, ALU always wins.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on posedge clk.
REQ-003 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port alu_valid, input, 1: ALU writeback request.
REQ-005 SHALL have port alu_addr, input, 5: ALU destination register.
REQ-006 SHALL have port alu_data, input, 32: ALU result.
REQ-007 SHALL have port alu_ready, output, 1: ALU request accepted this cycle.
REQ-008 SHALL have port mem_valid, input, 1: load-unit writeback request.
REQ-009 SHALL have port mem_addr, input, 5: load-unit destination register.
REQ-010 SHALL have port mem_data, input, 32: load data.
REQ-011 SHALL have port mem_ready, output, 1: load-unit request accepted this cycle.
REQ-012 SHALL have port reserve_en, input, 1: issue stage marks a destination pending.
REQ-013 SHALL have port reserve_addr, input, 5: register to mark pending.
REQ-014 SHALL have ports rs1_addr and rs2_addr, input, 5 each: source registers of the instruction in decode.
REQ-015 SHALL have port hazard, output, 1: a source register is pending; decode must stall.
REQ-016 SHALL have port write_enable, output, 1: drives the register-file write port.
REQ-017 SHALL have port write_addr, output, 5: drives the register-file write port.
REQ-018 SHALL have port write_data, output, 32: drives the register-file write port.
REQ-019 SHALL have port busy, output, 32: scoreboard, one bit per register.

Function
REQ-020 SHALL compute the grant combinationally each cycle; at most one of alu_ready and mem_ready is 1.
REQ-021 SHALL drive ready=0 for a requester whose valid=0.
REQ-022 SHALL grant a lone valid requester in the same cycle.
REQ-023 SHALL, on conflict with RR_EN=1, grant the requester not in last_grant.
REQ-024 SHALL, on conflict with RR_EN=0, grant ALU.
REQ-025 SHALL treat a transfer as valid && ready on either requester.
REQ-026 SHALL set last_grant to the granted source on every transfer and hold it otherwise.
REQ-027 SHALL register each transfer: write_enable=1 and write_addr/write_data = the granted pair in the next cycle, for exactly one cycle (latency 1).
REQ-028 SHALL drive write_enable=0 in any cycle with no transfer on the previous edge; write_addr and write_data then hold their last value.
REQ-029 SHALL accept (ready=1) a granted request to address 0 but not assert write_enable for it.
REQ-030 SHALL set busy[reserve_addr] on an edge with reserve_en=1 and reserve_addr!=0.
REQ-031 SHALL clear busy[write_addr] on an edge with write_enable=1, i.e. the edge on which the register file performs the write.
REQ-032 SHALL let set win when set and clear target the same register on the same edge.
REQ-033 SHALL keep busy[0] constant 0.
REQ-034 SHALL drive hazard combinationally: (rs1_addr!=0 && busy[rs1_addr]) || (rs2_addr!=0 && busy[rs2_addr]).
REQ-035 SHALL keep hazard at 1 during the write_enable cycle, because the register file reads asynchronously and the new value is visible only after that edge.
REQ-036 SHALL NOT rely on a rejected requester holding valid; arbitration decides from inputs only.

Reset
REQ-037 SHALL, while rst=1 at a posedge, set write_enable=0, write_addr=0, write_data=0, busy=0 and last_grant=MEM, so ALU wins the first conflict.
REQ-038 SHALL ignore transfers and reservations on an edge with rst=1; a write registered before reset is discarded (write_enable=0 after the reset edge).
REQ-039 SHALL drive the ready outputs combinationally with no special reset gating.

Verification
REQ-040 Lone request: alu_valid=1, alu_addr=5, alu_data=0xDEADBEEF -> alu_ready=1 in the same cycle; next cycle write_enable=1, write_addr=5, write_data=0xDEADBEEF; write_enable=0 the following cycle.
REQ-041 Conflict RR_EN=1 after reset, both valid for 3 cycles -> grants ALU, MEM, ALU; write_addr sequence follows one cycle later.
REQ-042 Conflict RR_EN=0, both valid for 3 cycles -> ALU granted every cycle; mem_ready stays 0.
REQ-043 Scoreboard: reserve x7; rs1_addr=7 -> hazard=1 the next cycle; MEM writes x7 -> hazard stays 1 through the write_enable cycle and is 0 the cycle after.
REQ-044 Same-edge set and clear on x3 -> busy[3]=1 afterwards; reserve x0 -> busy[0]=0 and hazard=0 for rs1_addr=0.
REQ-045 Reset mid-operation: transfer on edge N, rst=1 on edge N+1 -> write_enable=0 and busy=0 after edge N+1; ALU wins the next conflict.
